// File: rtl/pht_update_queue.sv
// Buffers gshare PHT counter updates until the write port is free; build with PHT_UPDATE_MERGE_EN to fold repeat updates into the tail entry.
// Latency: a push in cycle N reaches the head in cycle N+1. Drain stalls while port_busy holds the port.
// Backpressure: none upstream; a push into a full queue without a same-cycle pop is dropped and flagged next cycle.
module pht_update_queue #(
    parameter int QUEUE_SIZE          = 32,
    parameter int PHT_ENTRY_NUM       = 2048,
    parameter int HIST_WIDTH          = 10,
    parameter int PC_WIDTH            = 32,
    parameter int INSN_ADDR_BIT_WIDTH = 2,
    localparam int PHT_IDX_W          = $clog2(PHT_ENTRY_NUM),
    localparam int CNT_W              = $clog2(QUEUE_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    input  logic                  upd_is_cond,
    input  logic [PC_WIDTH-1:0]   upd_addr,
    input  logic [HIST_WIDTH-1:0] upd_history,
    input  logic                  upd_exec_taken,
    input  logic [1:0]            upd_prev_cnt,
    input  logic                  port_busy,
    output logic                  pht_we,
    output logic [PHT_IDX_W-1:0]  pht_wa,
    output logic [1:0]            pht_wv,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  drop
);

    localparam int PTR_W  = $clog2(QUEUE_SIZE);
    localparam int ADDR_W = PC_WIDTH - INSN_ADDR_BIT_WIDTH;
    localparam int XW     = (ADDR_W > HIST_WIDTH) ? ADDR_W : HIST_WIDTH;

    logic [PHT_IDX_W-1:0] idx_q [QUEUE_SIZE];
    logic [1:0]           val_q [QUEUE_SIZE];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;

    logic [XW-1:0]        addr_ext;
    logic [XW-1:0]        hist_ext;
    logic [PHT_IDX_W-1:0] new_idx;
    logic [1:0]           new_cnt;
    logic                 push;
    logic                 pop;
    logic                 merge;
    logic                 enq;

    assign addr_ext = XW'(upd_addr[PC_WIDTH-1:INSN_ADDR_BIT_WIDTH]);
    assign hist_ext = XW'(upd_history);
    assign new_idx  = PHT_IDX_W'(addr_ext ^ hist_ext);

    always_comb begin
        new_cnt = upd_prev_cnt;
        if (upd_exec_taken) begin
            if (upd_prev_cnt != 2'd3) new_cnt = upd_prev_cnt + 2'd1;
        end else begin
            if (upd_prev_cnt != 2'd0) new_cnt = upd_prev_cnt - 2'd1;
        end
    end

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(QUEUE_SIZE));
    assign count  = count_q;
    assign drop   = drop_q;
    assign pht_we = !empty && !port_busy;
    assign pht_wa = idx_q[head_q];
    assign pht_wv = val_q[head_q];

    assign push = upd_valid && upd_is_cond;
    assign pop  = pht_we;

`ifdef PHT_UPDATE_MERGE_EN
    logic [PTR_W-1:0] tail_m1;
    assign tail_m1 = tail_q - PTR_W'(1);
    // The tail entry can only be leaving this cycle when it is also the sole (head) entry.
    assign merge   = push && !empty && (idx_q[tail_m1] == new_idx)
                     && !(pop && (count_q == CNT_W'(1)));
`else
    assign merge   = 1'b0;
`endif

    // A full queue still accepts a push when the head drains in the same cycle.
    assign enq = push && !merge && (!full || pop);

    always_comb begin
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        drop_d  = push && !merge && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            idx_q[tail_q] <= new_idx;
            val_q[tail_q] <= new_cnt;
        end
`ifdef PHT_UPDATE_MERGE_EN
        if (merge) begin
            val_q[tail_m1] <= new_cnt;
        end
`endif
    end

endmodule

// File: tb/tb_pht_update_queue.sv
// Self-checking bench for pht_update_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pht_update_queue;

    localparam int QS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_is_cond;
    logic [31:0] upd_addr;
    logic [9:0]  upd_history;
    logic        upd_exec_taken;
    logic [1:0]  upd_prev_cnt;
    logic        port_busy;
    logic        pht_we;
    logic [10:0] pht_wa;
    logic [1:0]  pht_wv;
    logic        empty;
    logic        full;
    logic [5:0]  count;
    logic        drop;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int idx;
        int val;
    } ent_t;

    ent_t mq[$];
    int   m_drop = 0;

    always #5 clk = ~clk;

    pht_update_queue #(
        .QUEUE_SIZE(32), .PHT_ENTRY_NUM(2048), .HIST_WIDTH(10),
        .PC_WIDTH(32), .INSN_ADDR_BIT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_addr(upd_addr),
        .upd_history(upd_history), .upd_exec_taken(upd_exec_taken),
        .upd_prev_cnt(upd_prev_cnt), .port_busy(port_busy),
        .pht_we(pht_we), .pht_wa(pht_wa), .pht_wv(pht_wv),
        .empty(empty), .full(full), .count(count), .drop(drop)
    );

    function automatic int ref_idx(int unsigned addr, int unsigned hist);
        return int'(((addr >> 2) ^ hist) % 2048);
    endfunction

    function automatic int ref_cnt(bit taken, int prev);
        if (taken) return (prev == 3) ? 3 : prev + 1;
        return (prev == 0) ? 0 : prev - 1;
    endfunction

    task automatic set_in(bit v, bit c, int unsigned addr, int unsigned hist, bit t, int prev, bit busy);
        upd_valid      = v;
        upd_is_cond    = c;
        upd_addr       = addr;
        upd_history    = hist[9:0];
        upd_exec_taken = t;
        upd_prev_cnt   = prev[1:0];
        port_busy      = busy;
    endtask

    task automatic idle(bit busy);
        set_in(1'b0, 1'b0, 0, 0, 1'b0, 0, busy);
    endtask

    // Clock edge plus reference-model update from the inputs the bench is driving.
    task automatic advance();
        bit   pop;
        bit   push;
        bit   mrg;
        int   ni;
        int   nv;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_drop = 0;
        end else begin
            pop  = (mq.size() > 0) && !port_busy;
            push = upd_valid && upd_is_cond;
            ni   = ref_idx(upd_addr, upd_history);
            nv   = ref_cnt(upd_exec_taken, upd_prev_cnt);
            mrg  = 1'b0;
`ifdef PHT_UPDATE_MERGE_EN
            if (push && mq.size() > 0 && mq[mq.size()-1].idx == ni && !(pop && mq.size() == 1))
                mrg = 1'b1;
`endif
            if (pop) void'(mq.pop_front());
            m_drop = 0;
            if (mrg) begin
                e = mq.pop_back();
                e.val = nv;
                mq.push_back(e);
            end else if (push) begin
                if (mq.size() < QS) begin
                    e.idx = ni;
                    e.val = nv;
                    mq.push_back(e);
                end else begin
                    m_drop = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(1'b0);
        advance();
        advance();
        rst = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        n_tests++; if (pht_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", pht_we); end
        n_tests++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%0b exp=0", drop); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full); end
        advance();
        #1;
        n_tests++; if (empty !== 1'b1 || pht_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle got=%0b/%0b exp=1/0", empty, pht_we); end
    endtask

    task automatic test_basic();
        set_in(1'b1, 1'b1, 32'h100, 0, 1'b1, 1, 1'b0);
        #1;
        n_tests++; if (pht_we !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got=%0b exp=0", pht_we); end
        advance();
        idle(1'b0);
        #1;
        n_tests++; if (pht_we !== 1'b1) begin n_fail++; $display("FAIL basic_we got=%0b exp=1", pht_we); end
        n_tests++; if (pht_wa !== 11'h040) begin n_fail++; $display("FAIL basic_wa got=%0h exp=040", pht_wa); end
        n_tests++; if (pht_wv !== 2'd2) begin n_fail++; $display("FAIL basic_wv got=%0d exp=2", pht_wv); end
        advance();
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after got=%0b exp=1", empty); end
    endtask

    task automatic test_saturation();
        set_in(1'b1, 1'b1, 32'h20, 0, 1'b1, 3, 1'b1);
        advance();
        set_in(1'b1, 1'b1, 32'h40, 0, 1'b0, 0, 1'b1);
        advance();
        set_in(1'b1, 1'b0, 32'h60, 0, 1'b1, 1, 1'b1);
        advance();
        idle(1'b1);
        #1;
        n_tests++; if (count !== 6'd2) begin n_fail++; $display("FAIL sat_count got=%0d exp=2", count); end
        idle(1'b0);
        #1;
        n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'h008 || pht_wv !== 2'd3) begin
            n_fail++; $display("FAIL sat_taken got=%0b/%0h/%0d exp=1/008/3", pht_we, pht_wa, pht_wv); end
        advance();
        #1;
        n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'h010 || pht_wv !== 2'd0) begin
            n_fail++; $display("FAIL sat_not_taken got=%0b/%0h/%0d exp=1/010/0", pht_we, pht_wa, pht_wv); end
        advance();
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sat_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < QS; i++) begin
            set_in(1'b1, 1'b1, i << 2, 0, 1'b1, 1, 1'b1);
            advance();
        end
        idle(1'b1);
        #1;
        n_tests++; if (full !== 1'b1 || count !== 6'd32) begin n_fail++; $display("FAIL fill_full got=%0b/%0d exp=1/32", full, count); end
        n_tests++; if (pht_we !== 1'b0) begin n_fail++; $display("FAIL fill_busy_we got=%0b exp=0", pht_we); end
        set_in(1'b1, 1'b1, 100 << 2, 0, 1'b0, 2, 1'b1);
        #1;
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL ovf_drop_early got=%0b exp=0", drop); end
        advance();
        idle(1'b1);
        #1;
        n_tests++; if (drop !== 1'b1 || count !== 6'd32) begin n_fail++; $display("FAIL ovf_drop got=%0b/%0d exp=1/32", drop, count); end
        advance();
        #1;
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL ovf_drop_pulse got=%0b exp=0", drop); end
        for (int i = 0; i < QS; i++) begin
            idle(1'b0);
            #1;
            n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'(i) || pht_wv !== 2'd2) begin
                n_fail++; $display("FAIL drain_order i=%0d got=%0b/%0d/%0d exp=1/%0d/2", i, pht_we, pht_wa, pht_wv, i); end
            advance();
        end
        #1;
        n_tests++; if (empty !== 1'b1 || count !== 6'd0) begin n_fail++; $display("FAIL drain_empty got=%0b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < QS; i++) begin
            set_in(1'b1, 1'b1, (200 + i) << 2, 0, $urandom_range(0, 1), $urandom_range(0, 3), 1'b1);
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b1, (300 + k) << 2, 0, 1'b1, 2, 1'b0);
            #1;
            n_tests++; if (count !== 6'd32 || pht_we !== 1'b1 || int'(pht_wa) != mq[0].idx) begin
                n_fail++; $display("FAIL fpp_head k=%0d got=%0d/%0b/%0d exp=32/1/%0d", k, count, pht_we, pht_wa, mq[0].idx); end
            advance();
        end
        idle(1'b1);
        #1;
        n_tests++; if (count !== 6'd32 || drop !== 1'b0) begin n_fail++; $display("FAIL fpp_count got=%0d/%0b exp=32/0", count, drop); end
        for (int i = 0; i < QS; i++) begin
            idle(1'b0);
            #1;
            n_tests++; if (pht_we !== 1'b1 || int'(pht_wa) != mq[0].idx || int'(pht_wv) != mq[0].val) begin
                n_fail++; $display("FAIL fpp_wrap i=%0d got=%0b/%0d/%0d exp=1/%0d/%0d", i, pht_we, pht_wa, pht_wv, mq[0].idx, mq[0].val); end
            advance();
        end
    endtask

    task automatic test_merge();
        int exp_cnt;
`ifdef PHT_UPDATE_MERGE_EN
        exp_cnt = 1;
`else
        exp_cnt = 2;
`endif
        set_in(1'b1, 1'b1, 7 << 2, 0, 1'b1, 0, 1'b1);
        advance();
        set_in(1'b1, 1'b1, 7 << 2, 0, 1'b1, 1, 1'b1);
        advance();
        idle(1'b1);
        #1;
        n_tests++; if (int'(count) != exp_cnt) begin n_fail++; $display("FAIL merge_count got=%0d exp=%0d", count, exp_cnt); end
        idle(1'b0);
        #1;
`ifdef PHT_UPDATE_MERGE_EN
        n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'd7 || pht_wv !== 2'd2) begin
            n_fail++; $display("FAIL merge_write got=%0b/%0d/%0d exp=1/7/2", pht_we, pht_wa, pht_wv); end
        advance();
`else
        n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'd7 || pht_wv !== 2'd1) begin
            n_fail++; $display("FAIL nomerge_first got=%0b/%0d/%0d exp=1/7/1", pht_we, pht_wa, pht_wv); end
        advance();
        #1;
        n_tests++; if (pht_we !== 1'b1 || pht_wa !== 11'd7 || pht_wv !== 2'd2) begin
            n_fail++; $display("FAIL nomerge_second got=%0b/%0d/%0d exp=1/7/2", pht_we, pht_wa, pht_wv); end
        advance();
`endif
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL merge_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_random();
        bit         busy;
        bit         exp_empty;
        bit         exp_full;
        bit         exp_we;
        logic [5:0] exp_count;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            rst  = ($urandom_range(0, 299) == 0);
            busy = ((cyc / 100) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                   ($urandom_range(0, 15) << 2) | $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3), busy);
            #1;
            exp_empty = (mq.size() == 0);
            exp_full  = (mq.size() == QS);
            exp_we    = !exp_empty && !busy;
            exp_count = 6'(mq.size());
            n_tests++; if (empty !== exp_empty || full !== exp_full || count !== exp_count) begin
                n_fail++; $display("FAIL rand_occ cyc=%0d got=%0b/%0b/%0d exp=%0b/%0b/%0d", cyc, empty, full, count, exp_empty, exp_full, exp_count); end
            n_tests++; if (drop !== 1'(m_drop)) begin
                n_fail++; $display("FAIL rand_drop cyc=%0d got=%0b exp=%0d", cyc, drop, m_drop); end
            n_tests++; if (pht_we !== exp_we) begin
                n_fail++; $display("FAIL rand_we cyc=%0d got=%0b exp=%0b", cyc, pht_we, exp_we); end
            if (exp_we) begin
                n_tests++; if (int'(pht_wa) != mq[0].idx || int'(pht_wv) != mq[0].val) begin
                    n_fail++; $display("FAIL rand_head cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, pht_wa, pht_wv, mq[0].idx, mq[0].val); end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_fill_overflow();
        test_full_push_pop();
        test_merge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
